// File: rtl/cache_refill_fsm_pkg.sv
// Shared types and default parameters for the cache refill controller.
package cache_pkg;

  localparam int ADDR_W_DEF          = 16;
  localparam int WORDS_PER_BLOCK_DEF = 8;
  localparam int WORD_BYTES_DEF      = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/cache_refill_fsm_if.sv
// Miss / memory / data-array signal bundle between tag logic, memory and the refill FSM.
interface cache_refill_fsm_if
  import cache_pkg::*;
#(
  parameter int ADDR_W          = ADDR_W_DEF,
  parameter int WORDS_PER_BLOCK = WORDS_PER_BLOCK_DEF
) ();

  localparam int IDX_W = $clog2(WORDS_PER_BLOCK);

  logic              miss_detected;
  logic [ADDR_W-1:0] miss_address;
  logic              memory_data_valid;
  logic              fsm_busy;
  logic              memory_read_en;
  logic [ADDR_W-1:0] memory_address;
  logic              write_data_array;
  logic [IDX_W-1:0]  word_index;
  logic              write_tag_array;

  modport slave (
    input  miss_detected, miss_address, memory_data_valid,
    output fsm_busy, memory_read_en, memory_address,
           write_data_array, word_index, write_tag_array
  );

  modport master (
    output miss_detected, miss_address, memory_data_valid,
    input  fsm_busy, memory_read_en, memory_address,
           write_data_array, word_index, write_tag_array
  );

endinterface

// File: rtl/cache_refill_fsm_counter.sv
// Wrapping block-offset counter with load; also counts steps taken since the last load.
module refill_offset_counter #(
  parameter int COUNT = 8,
  parameter int OFF_W = $clog2(COUNT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [OFF_W-1:0] start,
  input  logic             en,
  output logic [OFF_W-1:0] offset,
  output logic [OFF_W:0]   count
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      offset <= '0;
      count  <= '0;
    end else if (load) begin
      offset <= start;
      count  <= '0;
    end else if (en) begin
      // COUNT is a power of two, so the natural overflow is the block wrap.
      offset <= offset + 1'b1;
      count  <= count + 1'b1;
    end
  end

endmodule

// File: rtl/cache_refill_fsm.sv
// Cache-miss block refill controller: issues one word read per cycle, writes returns.
// Optional macro CRITICAL_WORD_FIRST_EN starts both offsets at the missed word.
module cache_refill_fsm
  import cache_pkg::*;
#(
  parameter int ADDR_W          = ADDR_W_DEF,
  parameter int WORDS_PER_BLOCK = WORDS_PER_BLOCK_DEF,
  parameter int WORD_BYTES      = WORD_BYTES_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cache_refill_fsm_if.slave     bus
);

  localparam int IDX_W  = $clog2(WORDS_PER_BLOCK);
  localparam int BYTE_W = $clog2(WORD_BYTES);
  localparam int BLK_W  = IDX_W + BYTE_W;
  localparam logic [IDX_W:0] LAST_CNT = (IDX_W+1)'(WORDS_PER_BLOCK - 1);
  localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(WORDS_PER_BLOCK);

  state_e                    state_q, state_d;
  logic [ADDR_W-BLK_W-1:0]   block_q;
  logic                      start_refill;
  logic                      in_fill;
  logic                      final_word;
  logic [IDX_W-1:0]          start_offset;
  logic [IDX_W-1:0]          issue_offset, return_offset;
  logic [IDX_W:0]            issue_count, return_count;

  assign start_refill = (state_q == IDLE) && bus.miss_detected;
  assign in_fill      = (state_q == FILL);

`ifdef CRITICAL_WORD_FIRST_EN
  assign start_offset = bus.miss_address[BLK_W-1:BYTE_W];
`else
  assign start_offset = '0;
`endif

  refill_offset_counter #(.COUNT(WORDS_PER_BLOCK)) u_issue (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (start_refill),
    .start  (start_offset),
    .en     (bus.memory_read_en),
    .offset (issue_offset),
    .count  (issue_count)
  );

  refill_offset_counter #(.COUNT(WORDS_PER_BLOCK)) u_return (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (start_refill),
    .start  (start_offset),
    .en     (bus.write_data_array),
    .offset (return_offset),
    .count  (return_count)
  );

  // Only the block part of the miss is kept; word bits come from the issue offset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      block_q <= '0;
    end else begin
      state_q <= state_d;
      if (start_refill) block_q <= bus.miss_address[ADDR_W-1:BLK_W];
    end
  end

  assign final_word = bus.write_data_array && (return_count == LAST_CNT);

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.miss_detected) state_d = FILL;
      FILL:    if (final_word)        state_d = DONE;
      DONE:                           state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
  end

  // Busy is gated by rst_n so a miss seen during reset cannot stall the pipeline.
  assign bus.fsm_busy         = rst_n && ((state_q != IDLE) || bus.miss_detected);
  assign bus.memory_read_en   = in_fill && (issue_count != FULL_CNT);
  assign bus.memory_address   = bus.memory_read_en
                                ? ({block_q, {BLK_W{1'b0}}} | (ADDR_W'(issue_offset) << BYTE_W))
                                : '0;
  assign bus.write_data_array = in_fill && bus.memory_data_valid;
  assign bus.word_index       = return_offset;
  assign bus.write_tag_array  = final_word;

endmodule

// File: tb/tb_cache_refill_fsm.sv
// Directed self-checking bench for cache_refill_fsm (8 words/block, 2-byte words).
module tb_cache_refill_fsm;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  cache_refill_fsm_if #(.ADDR_W(16), .WORDS_PER_BLOCK(8)) bus ();

  cache_refill_fsm #(.ADDR_W(16), .WORDS_PER_BLOCK(8), .WORD_BYTES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic int start_of(input logic [15:0] addr);
`ifdef CRITICAL_WORD_FIRST_EN
    return int'(addr[3:1]);
`else
    return 0;
`endif
  endfunction

  // Drive inputs just after the rising edge, sample 2 time units later.
  task automatic next_cycle(input logic miss, input logic [15:0] addr, input logic vld);
    @(posedge clk);
    #1;
    bus.miss_detected     = miss;
    bus.miss_address      = addr;
    bus.memory_data_valid = vld;
    #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.miss_detected = 1'b1; bus.miss_address = 16'h1234; bus.memory_data_valid = 1'b1;
    #2;
    checks++; if (bus.fsm_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.fsm_busy); end
    checks++; if (bus.memory_read_en !== 1'b0) begin errors++; $display("FAIL reset_rd got %b exp 0", bus.memory_read_en); end
    checks++; if (bus.memory_address !== 16'h0) begin errors++; $display("FAIL reset_addr got %h exp 0000", bus.memory_address); end
    checks++; if (bus.write_data_array !== 1'b0) begin errors++; $display("FAIL reset_wr got %b exp 0", bus.write_data_array); end
    checks++; if (bus.write_tag_array !== 1'b0) begin errors++; $display("FAIL reset_tag got %b exp 0", bus.write_tag_array); end
    checks++; if (bus.word_index !== 3'd0) begin errors++; $display("FAIL reset_idx got %0d exp 0", bus.word_index); end
    bus.miss_detected = 1'b0; bus.memory_data_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_idle_valids();
    for (int k = 0; k < 4; k++) begin
      next_cycle(1'b0, 16'h1234, 1'b1);
      checks++; if (bus.write_data_array !== 1'b0) begin errors++; $display("FAIL idle_wr k=%0d got %b exp 0", k, bus.write_data_array); end
      checks++; if (bus.write_tag_array !== 1'b0) begin errors++; $display("FAIL idle_tag k=%0d got %b exp 0", k, bus.write_tag_array); end
      checks++; if (bus.fsm_busy !== 1'b0) begin errors++; $display("FAIL idle_busy k=%0d got %b exp 0", k, bus.fsm_busy); end
      checks++; if (bus.memory_read_en !== 1'b0) begin errors++; $display("FAIL idle_rd k=%0d got %b exp 0", k, bus.memory_read_en); end
    end
    next_cycle(1'b0, 16'h0000, 1'b0);
  endtask

  // One full refill: miss in an IDLE cycle, 8 FILL issue cycles, returns lagging by 'lag'.
  task automatic do_refill(input logic [15:0] addr, input int lag, input bit scramble, input bit hold_miss);
    int          start;
    logic [15:0] base, exp_addr, cur_addr;
    logic        vld, exp_rd;
    int          exp_idx;
    start = start_of(addr);
    base  = addr & 16'hFFF0;
    next_cycle(1'b1, addr, 1'b0);
    checks++; if (bus.fsm_busy !== 1'b1) begin errors++; $display("FAIL miss_busy got %b exp 1", bus.fsm_busy); end
    checks++; if (bus.memory_read_en !== 1'b0) begin errors++; $display("FAIL miss_rd got %b exp 0", bus.memory_read_en); end
    for (int k = 0; k < 8 + lag; k++) begin
      cur_addr = (scramble && k >= 2) ? 16'hABCD : addr;
      vld      = (k >= lag);
      next_cycle(hold_miss, cur_addr, vld);
      exp_rd   = (k < 8);
      exp_addr = exp_rd ? (base | 16'(((start + k) % 8) * 2)) : 16'h0;
      exp_idx  = (start + k - lag) % 8;
      checks++; if (bus.fsm_busy !== 1'b1) begin errors++; $display("FAIL fill_busy k=%0d got %b exp 1", k, bus.fsm_busy); end
      checks++; if (bus.memory_read_en !== exp_rd) begin errors++; $display("FAIL fill_rd k=%0d got %b exp %b", k, bus.memory_read_en, exp_rd); end
      checks++; if (bus.memory_address !== exp_addr) begin errors++; $display("FAIL fill_addr k=%0d got %h exp %h", k, bus.memory_address, exp_addr); end
      checks++; if (bus.write_data_array !== vld) begin errors++; $display("FAIL fill_wr k=%0d got %b exp %b", k, bus.write_data_array, vld); end
      if (vld) begin
        checks++; if (int'(bus.word_index) != exp_idx) begin errors++; $display("FAIL fill_idx k=%0d got %0d exp %0d", k, bus.word_index, exp_idx); end
      end
      checks++; if (bus.write_tag_array !== (k == lag + 7)) begin errors++; $display("FAIL fill_tag k=%0d got %b exp %b", k, bus.write_tag_array, (k == lag + 7)); end
    end
    next_cycle(hold_miss, addr, 1'b1);
    checks++; if (bus.fsm_busy !== 1'b1) begin errors++; $display("FAIL done_busy got %b exp 1", bus.fsm_busy); end
    checks++; if (bus.memory_read_en !== 1'b0) begin errors++; $display("FAIL done_rd got %b exp 0", bus.memory_read_en); end
    checks++; if (bus.write_data_array !== 1'b0) begin errors++; $display("FAIL done_wr got %b exp 0", bus.write_data_array); end
    checks++; if (bus.write_tag_array !== 1'b0) begin errors++; $display("FAIL done_tag got %b exp 0", bus.write_tag_array); end
    next_cycle(hold_miss, addr, 1'b0);
    checks++; if (bus.fsm_busy !== hold_miss) begin errors++; $display("FAIL after_busy got %b exp %b", bus.fsm_busy, hold_miss); end
  endtask

  task automatic test_sequential_refill();
    do_refill(16'h1234, 4, 1'b0, 1'b0);
  endtask

  task automatic test_overlap_refill();
    do_refill(16'h1236, 1, 1'b0, 1'b0);
  endtask

  task automatic test_address_latch();
    do_refill(16'h1234, 4, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_fill();
    next_cycle(1'b1, 16'h1234, 1'b0);
    for (int k = 0; k < 6; k++) next_cycle(1'b1, 16'h1234, (k >= 1));
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus.fsm_busy !== 1'b0) begin errors++; $display("FAIL rstfill_busy got %b exp 0", bus.fsm_busy); end
    checks++; if (bus.memory_read_en !== 1'b0) begin errors++; $display("FAIL rstfill_rd got %b exp 0", bus.memory_read_en); end
    checks++; if (bus.memory_address !== 16'h0) begin errors++; $display("FAIL rstfill_addr got %h exp 0000", bus.memory_address); end
    checks++; if (bus.write_data_array !== 1'b0) begin errors++; $display("FAIL rstfill_wr got %b exp 0", bus.write_data_array); end
    checks++; if (bus.word_index !== 3'd0) begin errors++; $display("FAIL rstfill_idx got %0d exp 0", bus.word_index); end
    checks++; if (bus.write_tag_array !== 1'b0) begin errors++; $display("FAIL rstfill_tag got %b exp 0", bus.write_tag_array); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.miss_detected = 1'b0;
    for (int k = 0; k < 10; k++) begin
      next_cycle(1'b0, 16'h1234, 1'b1);
      checks++; if (bus.write_tag_array !== 1'b0) begin errors++; $display("FAIL post_rst_tag k=%0d got %b exp 0", k, bus.write_tag_array); end
      checks++; if (bus.write_data_array !== 1'b0) begin errors++; $display("FAIL post_rst_wr k=%0d got %b exp 0", k, bus.write_data_array); end
      checks++; if (bus.fsm_busy !== 1'b0) begin errors++; $display("FAIL post_rst_busy k=%0d got %b exp 0", k, bus.fsm_busy); end
    end
    next_cycle(1'b0, 16'h0000, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_addr;
    do_refill(16'h1234, 4, 1'b0, 1'b1);
    exp_addr = 16'h1230 | 16'(start_of(16'h1234) * 2);
    next_cycle(1'b0, 16'h1234, 1'b0);
    checks++; if (bus.memory_read_en !== 1'b1) begin errors++; $display("FAIL b2b_rd got %b exp 1", bus.memory_read_en); end
    checks++; if (bus.memory_address !== exp_addr) begin errors++; $display("FAIL b2b_addr got %h exp %h", bus.memory_address, exp_addr); end
    checks++; if (bus.fsm_busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b exp 1", bus.fsm_busy); end
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    bus.miss_detected     = 1'b0;
    bus.miss_address      = 16'h0;
    bus.memory_data_valid = 1'b0;
    test_reset();
    test_idle_valids();
    test_sequential_refill();
    test_overlap_refill();
    test_address_latch();
    test_reset_mid_fill();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_refill_fsm.md
CACHE_REFILL_FSM -- requirements
Module: cache_refill_fsm

Interface
REQ-001 Parameter ADDR_W, 16, address width in bits.
REQ-002 Parameter WORDS_PER_BLOCK, 8, words per cache block; power of two, at least 2.
REQ-003 Parameter WORD_BYTES, 2, bytes per memory word; power of two.
REQ-004 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port miss_detected  input  1  tag logic reports a miss.
REQ-007 Port miss_address  input  ADDR_W  address that missed.
REQ-008 Port memory_data_valid  input  1  one word returned this cycle, in issue order.
REQ-009 Port fsm_busy  output  1  refill in progress; used as pipeline stall.
REQ-010 Port memory_read_en  output  1  read request this cycle.
REQ-011 Port memory_address  output  ADDR_W  word address being requested.
REQ-012 Port write_data_array  output  1  write the returned word into the data array.
REQ-013 Port word_index  output  log2(WORDS_PER_BLOCK)  data-array word slot for the returned word.
REQ-014 Port write_tag_array  output  1  tag-array write enable, pulsed once per refill.

Function
REQ-015 The block SHALL implement three states:
- IDLE->FILL when miss_detected=1.
- FILL->DONE on the cycle the WORDS_PER_BLOCK-th valid is accepted.
- DONE->IDLE unconditionally after one cycle.
REQ-016 On the IDLE->FILL edge, the block SHALL latch miss_address; later changes to miss_address or miss_detected SHALL NOT affect the refill.
REQ-017 fsm_busy SHALL be (IDLE and miss_detected), or FILL, or DONE.
REQ-018 In FILL, the block SHALL issue one request per cycle until WORDS_PER_BLOCK requests are issued; memory_read_en=1 only during those cycles.
REQ-019 memory_address SHALL be latched block base (low log2(WORDS_PER_BLOCK*WORD_BYTES) bits zeroed) plus issue_offset*WORD_BYTES; the address SHALL be 0 when memory_read_en=0.
REQ-020 An independent return counter SHALL count accepted memory_data_valid pulses in FILL; write_data_array SHALL equal memory_data_valid in FILL; word_index SHALL be the return offset.
REQ-021 memory_data_valid in IDLE or DONE SHALL be ignored, with no output effect.
REQ-022 write_tag_array SHALL be high exactly in the cycle of the final accepted word.
REQ-023 A valid arriving in the same cycle as an issue SHALL advance both counters independently.
REQ-024 Offsets SHALL wrap modulo WORDS_PER_BLOCK with no carry into the tag or index bits.

Reset
REQ-025 rst_n=0 SHALL asynchronously force state IDLE, clear both counters and the latched address, and drive all outputs to 0, including during FILL; no tag write SHALL follow the reset.

Configuration
REQ-026 With CRITICAL_WORD_FIRST_EN defined, the issue and return offsets SHALL start at the missed word's offset and wrap.
REQ-027 Without CRITICAL_WORD_FIRST_EN, both offsets SHALL start at 0.

Structure
REQ-028 Package cache_pkg SHALL hold the state enum (IDLE, FILL, DONE) and the default parameter constants.
REQ-029 Sub-module refill_offset_counter (wrapping offset counter with load and count-enable) SHALL be instantiated twice: once for issue, once for return.

Verification
REQ-030 Miss 0x1234 with valids at cycle lag 4 -> addresses 0x1230, 0x1232, ... 0x123E on 8 consecutive cycles; word_index 0..7; write_tag_array on the 8th valid; fsm_busy falls 1 cycle later.
REQ-031 CRITICAL_WORD_FIRST_EN, miss 0x1236 -> addresses 0x1236 ... 0x123E, 0x1230 ... 0x1234; word_index 3,4,...,7,0,1,2.
REQ-032 Reset asserted after 5 valids -> all outputs 0 immediately; with miss_detected=0 afterwards, no write_tag_array.
REQ-033 Valids driven while IDLE -> no write_data_array.
REQ-034 miss_address changed to 0xABCD mid-FILL -> remaining addresses stay 0x123x.
REQ-035 miss_detected held high through DONE -> a new refill starts the cycle after DONE.
